// File: rtl/add_two_dec_sequencer.sv
// Keypad-entry controller for the two-digit decimal adder: syncs and debounces the
// one-hot key lines, captures operands A and B, then sequences one add and holds the result.
module add_two_dec_sequencer #(
  parameter int DEB_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] Dec,
  input  logic       Clr,
  output logic [3:0] DigA,
  output logic [3:0] DigB,
  output logic [4:0] Sum,
  output logic       SumValid,
  output logic       KeyStrobe,
  output logic       Err,
  output logic [1:0] Phase
);

  // state  | meaning
  // WAIT_A | waiting for the first operand key
  // WAIT_B | operand A held, waiting for the second operand key
  // ADD    | single cycle: Sum <= DigA + DigB
  // SHOW   | result held; a new press starts a chained entry
  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    ADD    = 2'b10,
    SHOW   = 2'b11
  } state_t;

  localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

  state_t        state;
  state_t        state_nxt;
  logic [9:0]    dec_sync;
  logic [CW-1:0] deb_cnt;
  logic          armed;
  logic          stable;
  logic          code_zero;
  logic          code_one_hot;
  logic          code_multi;
  logic          press;
  logic [3:0]    digit;

  // deb_cnt counts how many consecutive samples dec_sync has held its value, saturating.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dec_sync <= '0;
      deb_cnt  <= '0;
    end else begin
      dec_sync <= Dec;
      if (Dec != dec_sync)
        deb_cnt <= CW'(1);
      else if (deb_cnt != CW'(DEB_CYC))
        deb_cnt <= deb_cnt + CW'(1);
    end
  end

  assign stable       = (deb_cnt == CW'(DEB_CYC));
  assign code_zero    = (dec_sync == 10'd0);
  assign code_one_hot = !code_zero && ((dec_sync & (dec_sync - 10'd1)) == 10'd0);
  assign code_multi   = !code_zero && !code_one_hot;
  assign press        = stable && armed && code_one_hot && !Err;

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++)
      if (dec_sync[i]) digit = 4'(i);
  end

  // Any stable nonzero code (accepted, ignored or multi-key) consumes the press until release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      armed     <= 1'b1;
      Err       <= 1'b0;
      KeyStrobe <= 1'b0;
    end else begin
      if (stable) armed <= code_zero;
      if (Clr)
        Err <= 1'b0;
      else if (stable && code_multi)
        Err <= 1'b1;
      KeyStrobe <= press && !Clr;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= WAIT_A;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (Clr) begin
      state_nxt = WAIT_A;
    end else begin
      case (state)
        WAIT_A:  if (press) state_nxt = WAIT_B;
        WAIT_B:  if (press) state_nxt = ADD;
        ADD:     state_nxt = SHOW;
        SHOW:    if (press) state_nxt = WAIT_B;
        default: state_nxt = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DigA     <= '0;
      DigB     <= '0;
      Sum      <= '0;
      SumValid <= 1'b0;
    end else if (Clr) begin
      DigA     <= '0;
      DigB     <= '0;
      Sum      <= '0;
      SumValid <= 1'b0;
    end else begin
      case (state)
        WAIT_A: if (press) DigA <= digit;
        WAIT_B: if (press) DigB <= digit;
        ADD: begin
          Sum      <= {1'b0, DigA} + {1'b0, DigB};
          SumValid <= 1'b1;
        end
        SHOW: if (press) begin
          DigA     <= digit;
          DigB     <= '0;
          Sum      <= '0;
          SumValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Phase = state;
  end

endmodule
